packet_arbiter: RTL and testbench
=================================

PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 Parameter N_SRC, default 4: number of packet sources sharing one packet FIFO write port.
REQ-002 Parameter DEPTH, default 8: downstream FIFO depth, equal to the initial credit count.
REQ-003 Parameter CW, default 4: credit counter width; SHALL satisfy 2^CW > DEPTH.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 RESET  input  1  reset, synchronous, active-low.
REQ-006 ENABLE  input  1  grants allowed while high.
REQ-007 SRC_VALID  input  N_SRC  per-source word-valid.
REQ-008 SRC_DATA  input  32*N_SRC  per-source payload; source i occupies bits [32i+31:32i].
REQ-009 SRC_READY  output  N_SRC  per-source accept; combinational; at most one bit high.
REQ-010 FIFO_READ_PULSE  input  1  one-cycle pulse per word the FIFO pops; driven from the FIFO's PACKET_READY_OUT.
REQ-011 PACKET_READY  output  1  write strobe to the FIFO.
REQ-012 PAYLOAD_DATA  output  32  write data to the FIFO; valid when PACKET_READY=1.
REQ-013 GRANT_ID  output  log2(N_SRC)  source index of the current PACKET_READY word.
REQ-014 CREDITS  output  CW  free FIFO slots as tracked by the arbiter.
REQ-015 STATE  output  2  encoding: IDLE=0, RUN=1, DRAIN=2.
REQ-016 CREDIT_ERR  output  1  sticky flag for a credit overflow.

Function
REQ-017 Transfer condition: SRC_VALID[i] & SRC_READY[i] in state RUN; one word per cycle maximum.
REQ-018 SRC_READY[i]=1 only when all of the following hold:
  - STATE=RUN;
  - CREDITS!=0, using the registered value; a same-cycle FIFO_READ_PULSE is not counted;
  - i is the round-robin winner among the valid sources.
REQ-019 Round-robin order: search starts at last_grant+1 and wraps modulo N_SRC; last_grant updates only on a transfer.
REQ-020 Latency: a word accepted in cycle t SHALL produce PACKET_READY=1, PAYLOAD_DATA=word and GRANT_ID=i in cycle t+1, for exactly one cycle.
REQ-021 PACKET_READY=0 in any cycle that follows a cycle with no transfer; PAYLOAD_DATA and GRANT_ID hold their last values.
REQ-022 Credit update per cycle:
  - transfer only: CREDITS-1;
  - FIFO_READ_PULSE only: CREDITS+1;
  - both together: unchanged;
  - neither: unchanged.
REQ-023 A FIFO_READ_PULSE while CREDITS=DEPTH and no transfer is in progress: CREDITS SHALL saturate at DEPTH and CREDIT_ERR SHALL be set until reset.
REQ-024 CREDITS SHALL never go below 0; REQ-018 guarantees this by construction.
REQ-025 State IDLE goes to RUN when ENABLE=1.
REQ-026 State RUN goes to DRAIN when ENABLE=0; the word accepted in the last RUN cycle still emits PACKET_READY in the following cycle.
REQ-027 State DRAIN behaviour:
  - no grants are issued;
  - goes to IDLE when CREDITS=DEPTH (FIFO known empty);
  - goes to RUN if ENABLE returns to 1 before that.
REQ-028 In IDLE, SRC_READY=0 and the output strobe is idle.
REQ-029 Sources with SRC_VALID=0 are skipped without consuming a turn.
REQ-030 A source that deasserts SRC_VALID before acceptance SHALL lose nothing and SHALL NOT be granted.

Reset
REQ-031 When RESET=0 at a rising edge, the following values SHALL be loaded:
  - STATE=IDLE;
  - CREDITS=DEPTH;
  - last_grant=N_SRC-1, so source 0 has first priority;
  - PACKET_READY=0, PAYLOAD_DATA=0, GRANT_ID=0;
  - CREDIT_ERR=0.
REQ-032 Reset mid-operation SHALL discard any pending output strobe; the word accepted in the reset cycle SHALL NOT emit PACKET_READY.
REQ-033 FIFO_READ_PULSE SHALL be ignored during reset; the FIFO is reset in the same cycle.

Verification
REQ-034 Round-robin:
  - stimulus: ENABLE=1; sources 0..3 all valid with data 0xA0..0xA3, constant, for 8 cycles;
  - response: GRANT_ID sequence 0,1,2,3,0,1,2,3, each with PACKET_READY one cycle after SRC_READY.
REQ-035 Credit exhaustion:
  - stimulus: source 2 valid continuously; no FIFO_READ_PULSE;
  - response: exactly 8 transfers; CREDITS reaches 0 and SRC_READY stays 0.
  - stimulus: one FIFO_READ_PULSE;
  - response: CREDITS=1, and the next cycle accepts one word.
REQ-036 Simultaneous events:
  - stimulus: CREDITS=3; transfer and FIFO_READ_PULSE in the same cycle;
  - response: CREDITS=3 the next cycle.
REQ-037 Drain:
  - stimulus: ENABLE falls with CREDITS=5;
  - response: STATE=DRAIN, no new grants; after 3 read pulses, CREDITS=8 and STATE=IDLE.
REQ-038 Overflow:
  - stimulus: FIFO_READ_PULSE with CREDITS=8;
  - response: CREDITS=8, and CREDIT_ERR=1 held until RESET=0.
REQ-039 Reset mid-transfer:
  - stimulus: RESET=0 in the cycle source 1 is accepted;
  - response: PACKET_READY=0 the next cycle, CREDITS=8, and source 0 has priority afterwards.

Source files
------------

// File: rtl/packet_arbiter.sv
// rtl/packet_arbiter.sv - round-robin, credit-gated arbiter feeding one packet FIFO write port
//
// Ports:
//   CLK, RESET          clock (rising edge); synchronous active-low reset
//   ENABLE              allows grants while high; low drains the FIFO back to IDLE
//   SRC_VALID/SRC_DATA  per-source word offer; source i data in bits [32i+31:32i]
//   SRC_READY           per-source accept (combinational, one-hot or zero)
//   FIFO_READ_PULSE     one pulse per word popped by the downstream FIFO
//   PACKET_READY        FIFO write strobe, one cycle after the accept
//   PAYLOAD_DATA        FIFO write data, held between strobes
//   GRANT_ID            source index of the current strobe, held between strobes
//   CREDITS             free FIFO slots as tracked here
//   STATE               IDLE=0, RUN=1, DRAIN=2
//   CREDIT_ERR          sticky: read pulse seen with all credits already home
module packet_arbiter #(
  parameter int N_SRC = 4,
  parameter int DEPTH = 8,
  parameter int CW    = 4,
  localparam int GW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic [N_SRC-1:0]      SRC_VALID,
  input  logic [32*N_SRC-1:0]   SRC_DATA,
  output logic [N_SRC-1:0]      SRC_READY,
  input  logic                  FIFO_READ_PULSE,
  output logic                  PACKET_READY,
  output logic [31:0]           PAYLOAD_DATA,
  output logic [GW-1:0]         GRANT_ID,
  output logic [CW-1:0]         CREDITS,
  output logic [1:0]            STATE,
  output logic                  CREDIT_ERR
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CW-1:0] CRED_FULL = CW'(DEPTH);
  localparam logic [GW-1:0] LAST_SRC  = GW'(N_SRC - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic            pkt_ready_q, pkt_ready_d;
  logic [31:0]     payload_q, payload_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic            credit_err_q, credit_err_d;

  logic            hi_found, lo_found;
  logic [GW-1:0]   hi_idx, lo_idx, winner_idx;
  logic            winner_found;
  logic            grant_ok;
  logic            xfer;
  logic [N_SRC-1:0] src_ready;
  logic [31:0]     payload_sel;

  // Round-robin: the lowest valid index above last_grant wins; if none, wrap
  // to the lowest valid index overall. Invalid sources never take a turn.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (SRC_VALID[i]) begin
        lo_found = 1'b1;
        lo_idx   = GW'(i);
        if (GW'(i) > last_grant_q) begin
          hi_found = 1'b1;
          hi_idx   = GW'(i);
        end
      end
    end
    winner_found = lo_found;
    winner_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Grant uses the registered credit count only, so a read pulse in the same
  // cycle cannot be spent before it lands; credits therefore never underflow.
  always_comb begin
    grant_ok    = (state_q == ST_RUN) && (credits_q != '0) && winner_found;
    src_ready   = '0;
    payload_sel = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (GW'(i) == winner_idx) begin
        src_ready[i] = grant_ok;
        payload_sel  = SRC_DATA[32*i +: 32];
      end
    end
    xfer = grant_ok;
  end

  always_comb begin
    state_d      = state_q;
    credits_d    = credits_q;
    last_grant_d = last_grant_q;
    pkt_ready_d  = xfer;
    payload_d    = payload_q;
    grant_id_d   = grant_id_q;
    credit_err_d = credit_err_q;

    if (xfer) begin
      last_grant_d = winner_idx;
      payload_d    = payload_sel;
      grant_id_d   = winner_idx;
    end

    case ({xfer, FIFO_READ_PULSE})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        // A pop with every slot already credited means the FIFO and the
        // arbiter disagree; saturate and remember it.
        if (credits_q == CRED_FULL) begin
          credit_err_d = 1'b1;
        end else begin
          credits_d = credits_q + CW'(1);
        end
      end
      default: credits_d = credits_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        if (ENABLE) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!ENABLE) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Re-enable wins over completing the drain.
        if (ENABLE) begin
          state_d = ST_RUN;
        end else if (credits_q == CRED_FULL) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset also clears the output strobe, so a word accepted in the reset
  // cycle is dropped along with the FIFO contents.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      credits_q    <= CRED_FULL;
      last_grant_q <= LAST_SRC;
      pkt_ready_q  <= 1'b0;
      payload_q    <= '0;
      grant_id_q   <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      last_grant_q <= last_grant_d;
      pkt_ready_q  <= pkt_ready_d;
      payload_q    <= payload_d;
      grant_id_q   <= grant_id_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign SRC_READY    = src_ready;
  assign PACKET_READY = pkt_ready_q;
  assign PAYLOAD_DATA = payload_q;
  assign GRANT_ID     = grant_id_q;
  assign CREDITS      = credits_q;
  assign STATE        = state_q;
  assign CREDIT_ERR   = credit_err_q;

endmodule

// File: tb/tb_packet_arbiter.sv
// tb/tb_packet_arbiter.sv - directed self-checking bench for packet_arbiter
module tb_packet_arbiter;

  logic         CLK;
  logic         RESET;
  logic         ENABLE;
  logic [3:0]   SRC_VALID;
  logic [127:0] SRC_DATA;
  logic [3:0]   SRC_READY;
  logic         FIFO_READ_PULSE;
  logic         PACKET_READY;
  logic [31:0]  PAYLOAD_DATA;
  logic [1:0]   GRANT_ID;
  logic [3:0]   CREDITS;
  logic [1:0]   STATE;
  logic         CREDIT_ERR;

  int checks = 0;
  int errors = 0;

  packet_arbiter #(.N_SRC(4), .DEPTH(8), .CW(4)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ENABLE(ENABLE),
    .SRC_VALID(SRC_VALID),
    .SRC_DATA(SRC_DATA),
    .SRC_READY(SRC_READY),
    .FIFO_READ_PULSE(FIFO_READ_PULSE),
    .PACKET_READY(PACKET_READY),
    .PAYLOAD_DATA(PAYLOAD_DATA),
    .GRANT_ID(GRANT_ID),
    .CREDITS(CREDITS),
    .STATE(STATE),
    .CREDIT_ERR(CREDIT_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic test_reset;
    RESET = 1'b0; ENABLE = 1'b1; SRC_VALID = 4'hF; FIFO_READ_PULSE = 1'b1;
    @(negedge CLK); @(negedge CLK);
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL rst_state: got %0h expected 0", STATE); end
    checks++; if (CREDITS !== 4'd8) begin errors++; $display("FAIL rst_credits: got %0d expected 8", CREDITS); end
    checks++; if (PACKET_READY !== 1'b0) begin errors++; $display("FAIL rst_pkt_ready: got %0b expected 0", PACKET_READY); end
    checks++; if (PAYLOAD_DATA !== 32'h0) begin errors++; $display("FAIL rst_payload: got %0h expected 0", PAYLOAD_DATA); end
    checks++; if (GRANT_ID !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d expected 0", GRANT_ID); end
    checks++; if (CREDIT_ERR !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b expected 0", CREDIT_ERR); end
    RESET = 1'b1; ENABLE = 1'b0; FIFO_READ_PULSE = 1'b0;
    #1;
    checks++; if (SRC_READY !== 4'h0) begin errors++; $display("FAIL idle_ready: got %0h expected 0", SRC_READY); end
    @(negedge CLK);
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL idle_hold: got %0h expected 0", STATE); end
    checks++; if (PACKET_READY !== 1'b0) begin errors++; $display("FAIL idle_strobe: got %0b expected 0", PACKET_READY); end
    SRC_VALID = 4'h0;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    ENABLE = 1'b1;
    @(negedge CLK);
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL rr_run: got %0h expected 1", STATE); end
    SRC_VALID = 4'hF;
    for (int c = 0; c < 8; c++) begin
      exp_rdy = 4'h0;
      exp_rdy[c % 4] = 1'b1;
      #1;
      checks++; if (SRC_READY !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d]: got %0h expected %0h", c, SRC_READY, exp_rdy); end
      @(negedge CLK);
      checks++; if (PACKET_READY !== 1'b1) begin errors++; $display("FAIL rr_strobe[%0d]: got %0b expected 1", c, PACKET_READY); end
      checks++; if (GRANT_ID !== 2'(c % 4)) begin errors++; $display("FAIL rr_grant[%0d]: got %0d expected %0d", c, GRANT_ID, c % 4); end
      checks++; if (PAYLOAD_DATA !== 32'hA0 + 32'(c % 4)) begin errors++; $display("FAIL rr_data[%0d]: got %0h expected %0h", c, PAYLOAD_DATA, 32'hA0 + 32'(c % 4)); end
    end
    checks++; if (CREDITS !== 4'd0) begin errors++; $display("FAIL rr_credits: got %0d expected 0", CREDITS); end
    #1;
    checks++; if (SRC_READY !== 4'h0) begin errors++; $display("FAIL rr_nocredit_ready: got %0h expected 0", SRC_READY); end
    SRC_VALID = 4'h0;
    @(negedge CLK);
    checks++; if (PACKET_READY !== 1'b0) begin errors++; $display("FAIL rr_strobe_off: got %0b expected 0", PACKET_READY); end
    checks++; if (PAYLOAD_DATA !== 32'hA3) begin errors++; $display("FAIL rr_data_hold: got %0h expected a3", PAYLOAD_DATA); end
    checks++; if (GRANT_ID !== 2'd3) begin errors++; $display("FAIL rr_grant_hold: got %0d expected 3", GRANT_ID); end
    FIFO_READ_PULSE = 1'b1;
    repeat (8) @(negedge CLK);
    FIFO_READ_PULSE = 1'b0;
    checks++; if (CREDITS !== 4'd8) begin errors++; $display("FAIL rr_refill: got %0d expected 8", CREDITS); end
    checks++; if (CREDIT_ERR !== 1'b0) begin errors++; $display("FAIL rr_err: got %0b expected 0", CREDIT_ERR); end
  endtask

  task automatic test_credit_exhaust;
    int n;
    n = 0;
    SRC_VALID = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (SRC_READY[2] === 1'b1) n++;
      @(negedge CLK);
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL cx_count: got %0d expected 8", n); end
    checks++; if (CREDITS !== 4'd0) begin errors++; $display("FAIL cx_credits: got %0d expected 0", CREDITS); end
    FIFO_READ_PULSE = 1'b1;
    #1;
    checks++; if (SRC_READY !== 4'h0) begin errors++; $display("FAIL cx_same_cycle: got %0h expected 0", SRC_READY); end
    @(negedge CLK);
    FIFO_READ_PULSE = 1'b0;
    checks++; if (CREDITS !== 4'd1) begin errors++; $display("FAIL cx_one_credit: got %0d expected 1", CREDITS); end
    #1;
    checks++; if (SRC_READY !== 4'b0100) begin errors++; $display("FAIL cx_ready: got %0h expected 4", SRC_READY); end
    @(negedge CLK);
    checks++; if (PACKET_READY !== 1'b1) begin errors++; $display("FAIL cx_strobe: got %0b expected 1", PACKET_READY); end
    checks++; if (GRANT_ID !== 2'd2) begin errors++; $display("FAIL cx_grant: got %0d expected 2", GRANT_ID); end
    checks++; if (PAYLOAD_DATA !== 32'hA2) begin errors++; $display("FAIL cx_data: got %0h expected a2", PAYLOAD_DATA); end
    checks++; if (CREDITS !== 4'd0) begin errors++; $display("FAIL cx_credits_end: got %0d expected 0", CREDITS); end
    SRC_VALID = 4'h0;
    FIFO_READ_PULSE = 1'b1;
    repeat (8) @(negedge CLK);
    FIFO_READ_PULSE = 1'b0;
    checks++; if (CREDITS !== 4'd8) begin errors++; $display("FAIL cx_refill: got %0d expected 8", CREDITS); end
  endtask

  task automatic test_simultaneous;
    SRC_VALID = 4'b0010;
    repeat (5) @(negedge CLK);
    checks++; if (CREDITS !== 4'd3) begin errors++; $display("FAIL sim_pre: got %0d expected 3", CREDITS); end
    FIFO_READ_PULSE = 1'b1;
    #1;
    checks++; if (SRC_READY !== 4'b0010) begin errors++; $display("FAIL sim_ready: got %0h expected 2", SRC_READY); end
    @(negedge CLK);
    checks++; if (CREDITS !== 4'd3) begin errors++; $display("FAIL sim_credits: got %0d expected 3", CREDITS); end
    checks++; if (GRANT_ID !== 2'd1) begin errors++; $display("FAIL sim_grant: got %0d expected 1", GRANT_ID); end
    FIFO_READ_PULSE = 1'b0;
    SRC_VALID = 4'h0;
  endtask

  task automatic test_drain;
    FIFO_READ_PULSE = 1'b1;
    repeat (2) @(negedge CLK);
    FIFO_READ_PULSE = 1'b0;
    checks++; if (CREDITS !== 4'd5) begin errors++; $display("FAIL dr_pre: got %0d expected 5", CREDITS); end
    ENABLE = 1'b0;
    @(negedge CLK);
    checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL dr_state: got %0h expected 2", STATE); end
    SRC_VALID = 4'hF;
    FIFO_READ_PULSE = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (SRC_READY !== 4'h0) begin errors++; $display("FAIL dr_ready[%0d]: got %0h expected 0", c, SRC_READY); end
      @(negedge CLK);
      checks++; if (PACKET_READY !== 1'b0) begin errors++; $display("FAIL dr_strobe[%0d]: got %0b expected 0", c, PACKET_READY); end
    end
    FIFO_READ_PULSE = 1'b0;
    checks++; if (CREDITS !== 4'd8) begin errors++; $display("FAIL dr_credits: got %0d expected 8", CREDITS); end
    @(negedge CLK);
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL dr_idle: got %0h expected 0", STATE); end
    checks++; if (CREDIT_ERR !== 1'b0) begin errors++; $display("FAIL dr_err: got %0b expected 0", CREDIT_ERR); end
    SRC_VALID = 4'h0;
  endtask

  task automatic test_drain_last_word;
    ENABLE = 1'b1;
    @(negedge CLK);
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL lw_run: got %0h expected 1", STATE); end
    SRC_VALID = 4'b0001;
    ENABLE = 1'b0;
    #1;
    checks++; if (SRC_READY !== 4'b0001) begin errors++; $display("FAIL lw_ready: got %0h expected 1", SRC_READY); end
    @(negedge CLK);
    checks++; if (STATE !== 2'd2) begin errors++; $display("FAIL lw_state: got %0h expected 2", STATE); end
    checks++; if (PACKET_READY !== 1'b1) begin errors++; $display("FAIL lw_strobe: got %0b expected 1", PACKET_READY); end
    checks++; if (PAYLOAD_DATA !== 32'hA0) begin errors++; $display("FAIL lw_data: got %0h expected a0", PAYLOAD_DATA); end
    checks++; if (CREDITS !== 4'd7) begin errors++; $display("FAIL lw_credits: got %0d expected 7", CREDITS); end
    SRC_VALID = 4'h0;
    FIFO_READ_PULSE = 1'b1;
    @(negedge CLK);
    FIFO_READ_PULSE = 1'b0;
    checks++; if (CREDITS !== 4'd8) begin errors++; $display("FAIL lw_refill: got %0d expected 8", CREDITS); end
    @(negedge CLK);
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL lw_idle: got %0h expected 0", STATE); end
  endtask

  task automatic test_overflow;
    FIFO_READ_PULSE = 1'b1;
    @(negedge CLK);
    FIFO_READ_PULSE = 1'b0;
    checks++; if (CREDITS !== 4'd8) begin errors++; $display("FAIL ov_credits: got %0d expected 8", CREDITS); end
    checks++; if (CREDIT_ERR !== 1'b1) begin errors++; $display("FAIL ov_err: got %0b expected 1", CREDIT_ERR); end
    repeat (3) @(negedge CLK);
    checks++; if (CREDIT_ERR !== 1'b1) begin errors++; $display("FAIL ov_sticky: got %0b expected 1", CREDIT_ERR); end
  endtask

  task automatic test_reset_mid_transfer;
    ENABLE = 1'b1;
    @(negedge CLK);
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL rm_run: got %0h expected 1", STATE); end
    SRC_VALID = 4'b0010;
    #1;
    checks++; if (SRC_READY !== 4'b0010) begin errors++; $display("FAIL rm_ready: got %0h expected 2", SRC_READY); end
    RESET = 1'b0;
    @(negedge CLK);
    checks++; if (PACKET_READY !== 1'b0) begin errors++; $display("FAIL rm_strobe: got %0b expected 0", PACKET_READY); end
    checks++; if (CREDITS !== 4'd8) begin errors++; $display("FAIL rm_credits: got %0d expected 8", CREDITS); end
    checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL rm_state: got %0h expected 0", STATE); end
    checks++; if (CREDIT_ERR !== 1'b0) begin errors++; $display("FAIL rm_err: got %0b expected 0", CREDIT_ERR); end
    RESET = 1'b1;
    SRC_VALID = 4'hF;
    @(negedge CLK);
    checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL rm_rerun: got %0h expected 1", STATE); end
    #1;
    checks++; if (SRC_READY !== 4'b0001) begin errors++; $display("FAIL rm_prio: got %0h expected 1", SRC_READY); end
    @(negedge CLK);
    checks++; if (GRANT_ID !== 2'd0) begin errors++; $display("FAIL rm_grant: got %0d expected 0", GRANT_ID); end
    checks++; if (PACKET_READY !== 1'b1) begin errors++; $display("FAIL rm_strobe2: got %0b expected 1", PACKET_READY); end
    SRC_VALID = 4'h0;
  endtask

  initial begin
    RESET = 1'b0;
    ENABLE = 1'b0;
    SRC_VALID = 4'h0;
    SRC_DATA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    FIFO_READ_PULSE = 1'b0;
    test_reset();
    test_round_robin();
    test_credit_exhaust();
    test_simultaneous();
    test_drain();
    test_drain_last_word();
    test_overflow();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
